// File: rtl/kernel_cc_start_token_rx.sv
// Start-token receiver: pops tokens from a start FIFO, launches a downstream task per token,
// bounds outstanding iterations and reports completions. Statistics counters: KERNEL_CC_START_RX_STATS_EN.
module kernel_cc_start_token_rx #(
    parameter int DATA_WIDTH = 1,
    parameter int MAX_OUT    = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    output logic                  fifo_read_ce,
    output logic                  task_ap_start,
    output logic [DATA_WIDTH-1:0] task_token,
    input  logic                  task_ap_ready,
    input  logic                  task_ap_done,
    output logic                  task_ap_continue,
    output logic                  done_valid,
    input  logic                  done_ack,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  iter_count,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);

    typedef enum logic {
        IDLE  = 1'b0,
        START = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [OUT_W-1:0] outstanding;
    logic             start_acc;
    logic             done_acc;
    logic             at_limit;

    assign fifo_read_ce = 1'b1;
    assign at_limit     = (outstanding == MAX_OUT_V);

    // Pop, continue and busy are gated by reset so nothing leaves the FIFO while reset is high.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can be inferred.
        state_nxt        = state;
        fifo_read        = 1'b0;
        task_ap_start    = (state == START);
        task_ap_continue = reset | ~done_valid | done_ack;
        start_acc        = (state == START) & task_ap_ready;
        done_acc         = task_ap_done & task_ap_continue & (outstanding != '0);
        busy             = ~reset & ((state != IDLE) | (outstanding != '0) | done_valid);
        case (state)
            IDLE: begin
                if (!reset && fifo_empty_n && (outstanding < MAX_OUT_V)) begin
                    fifo_read = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (task_ap_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state       <= IDLE;
            outstanding <= '0;
            task_token  <= '0;
            done_valid  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fifo_read) task_token <= fifo_dout;
            case ({start_acc, done_acc})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
            // A new accepted done alongside an ack keeps the report valid back to back.
            done_valid <= done_acc | (done_valid & ~done_ack);
        end
    end

`ifdef KERNEL_CC_START_RX_STATS_EN
    logic [CNT_WIDTH-1:0] iter_q;
    logic [CNT_WIDTH-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            iter_q  <= '0;
            stall_q <= '0;
        end else begin
            if (done_acc) iter_q <= iter_q + CNT_WIDTH'(1);
            if (fifo_empty_n && at_limit && (stall_q != '1)) stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end

    assign iter_count   = iter_q;
    assign stall_cycles = stall_q;
`else
    logic unused_stats;
    assign unused_stats = at_limit;
    assign iter_count   = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_kernel_cc_start_token_rx.sv
// Randomized bench for kernel_cc_start_token_rx against a transaction-level model of
// tokens, outstanding iterations and completion reports.
module tb_kernel_cc_start_token_rx;

    localparam int DW = 4;
    localparam int MO = 2;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty_n;
    logic [DW-1:0] fifo_dout;
    logic          fifo_read;
    logic          fifo_read_ce;
    logic          task_ap_start;
    logic [DW-1:0] task_token;
    logic          task_ap_ready;
    logic          task_ap_done;
    logic          task_ap_continue;
    logic          done_valid;
    logic          done_ack;
    logic          busy;
    logic [CW-1:0] iter_count;
    logic [CW-1:0] stall_cycles;

    kernel_cc_start_token_rx #(
        .DATA_WIDTH(DW),
        .MAX_OUT   (MO),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty_n    (fifo_empty_n),
        .fifo_dout       (fifo_dout),
        .fifo_read       (fifo_read),
        .fifo_read_ce    (fifo_read_ce),
        .task_ap_start   (task_ap_start),
        .task_token      (task_token),
        .task_ap_ready   (task_ap_ready),
        .task_ap_done    (task_ap_done),
        .task_ap_continue(task_ap_continue),
        .done_valid      (done_valid),
        .done_ack        (done_ack),
        .busy            (busy),
        .iter_count      (iter_count),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

`ifdef KERNEL_CC_START_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a token is either waiting to be started or not; `m_out` counts tasks
    // running downstream; `m_report` is a completion not yet acknowledged.
    logic [DW-1:0] fifo_q[$];
    bit            m_starting;
    logic [DW-1:0] m_token;
    int            m_out;
    bit            m_report;
    int            m_iter;
    int            m_stall;

    function automatic void model_reset();
        m_starting = 0;
        m_token    = '0;
        m_out      = 0;
        m_report   = 0;
        m_iter     = 0;
        m_stall    = 0;
    endfunction

    task automatic cycle(input bit rst, input int p_ready, input int p_done, input int p_ack,
                         input int p_push);
        bit exp_pop, exp_cont, start_acc, done_acc, obs_pop, nonempty;
        reset         = rst;
        task_ap_ready = ($urandom_range(99) < p_ready);
        task_ap_done  = ($urandom_range(99) < p_done);
        done_ack      = ($urandom_range(99) < p_ack);
        if (($urandom_range(99) < p_push) && fifo_q.size() < 8) fifo_q.push_back(DW'($urandom));
        nonempty     = (fifo_q.size() != 0);
        fifo_empty_n = nonempty;
        fifo_dout    = nonempty ? fifo_q[0] : DW'($urandom);
        #4;
        exp_cont = !m_report || done_ack;
        exp_pop  = !rst && !m_starting && nonempty && (m_out < MO);
        if (rst) begin
            check("rst_fifo_read", fifo_read, 0);
            check("rst_busy", busy, 0);
            check("rst_continue", task_ap_continue, 1);
        end else begin
            check("fifo_read", fifo_read, exp_pop);
            check("fifo_read_ce", fifo_read_ce, 1);
            check("task_ap_start", task_ap_start, m_starting);
            check("task_token", task_token, m_token);
            check("task_ap_continue", task_ap_continue, exp_cont);
            check("done_valid", done_valid, m_report);
            check("busy", busy, m_starting || (m_out != 0) || m_report);
            check("iter_count", iter_count, STATS ? m_iter : 0);
            check("stall_cycles", stall_cycles, STATS ? m_stall : 0);
        end
        obs_pop = fifo_read;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            start_acc = m_starting && task_ap_ready;
            done_acc  = task_ap_done && exp_cont && (m_out > 0);
            if (nonempty && m_out == MO && m_stall < CNT_MAX) m_stall++;
            if (done_acc) m_iter = (m_iter + 1) % (CNT_MAX + 1);
            m_out    = m_out + int'(start_acc) - int'(done_acc);
            m_report = done_acc || (m_report && !done_ack);
            if (exp_pop) begin
                m_starting = 1;
                m_token    = fifo_q[0];
            end else if (start_acc) begin
                m_starting = 0;
            end
        end
        if (obs_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        #1;
    endtask

    initial begin
        model_reset();
        reset = 1'b1; task_ap_ready = 0; task_ap_done = 0; done_ack = 0;
        fifo_empty_n = 0; fifo_dout = '0;
        repeat (3) cycle(1, 0, 0, 0, 0);
        // Reset-state values after the reset edges.
        #4;
        check("reset_task_ap_start", task_ap_start, 0);
        check("reset_task_token", task_token, 0);
        check("reset_done_valid", done_valid, 0);
        @(posedge clk); #1;

        // General mix with occasional mid-operation resets.
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(99) < 1, 60, 40, 60, 50);
        // Outstanding limit held with tokens queued: stall counter saturates.
        for (int i = 0; i < 300; i++) cycle(0, 90, 0, 50, 60);
        // Done held high while acks are withheld, then released.
        for (int i = 0; i < 200; i++) cycle(0, 70, 100, 10, 50);
        // Fast drain: every done and ack taken immediately.
        for (int i = 0; i < 1500; i++) cycle(0, 80, 70, 100, 70);
        // Empty FIFO and idle downstream: block must go quiet.
        for (int i = 0; i < 1000; i++) cycle(0, 50, 50, 50, 0);
        for (int i = 0; i < 40; i++) cycle(0, 100, 100, 100, 0);
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
